// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, constants and gap helpers for the pipe column generator
package pipe_pkg;

    localparam int         ROWS      = 8;
    localparam int         GAP_H_DEF = 3;
    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a shift-left register: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] SEED_DEF  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PIPE = 2'd2
    } state_t;

    // Fold a 3-bit random value onto the legal opening positions 0..ROWS-gap_h
    function automatic logic [2:0] gap_pos_of(input logic [2:0] raw, input int gap_h);
        int lim;
        lim = ROWS - gap_h + 1;
        if (int'(raw) >= lim) begin
            return 3'(int'(raw) - lim);
        end
        return raw;
    endfunction

    // Column pattern: all rows lit except the gap_h rows starting at pos
    function automatic logic [ROWS-1:0] gap_mask(input logic [2:0] pos, input int gap_h);
        logic [ROWS-1:0] m;
        m = '1;
        for (int i = 0; i < ROWS; i++) begin
            if (i >= int'(pos) && i < int'(pos) + gap_h) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_gen_if.sv
// rtl/pipe_gen_if.sv - game-control inputs and column stream outputs of the pipe generator
interface pipe_gen_if;
    import pipe_pkg::*;

    logic            ongoing;
    logic            gameOver;
    logic [ROWS-1:0] next;
    logic            step;
    logic [2:0]      gap_pos;
    logic            pipe_done;

    modport master (
        input  ongoing, gameOver,
        output next, step, gap_pos, pipe_done
    );

    modport slave (
        output ongoing, gameOver,
        input  next, step, gap_pos, pipe_done
    );

endinterface

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR with enable and configurable seed
module lfsr8
    import pipe_pkg::*;
#(
    parameter logic [7:0] SEED = SEED_DEF
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;

    // Shift left, feeding back the XOR of the tapped bits; a non-zero seed never reaches zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else if (i_enable) begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/pipe_gen.sv
// rtl/pipe_gen.sv - emits alternating gap and pipe columns, one per scroll step
module pipe_gen
    import pipe_pkg::*;
#(
    parameter int         STEP_DIV = 256,
    parameter int         PIPE_W   = 2,
    parameter int         GAP_COLS = 4,
    parameter int         GAP_H    = GAP_H_DEF,
    parameter logic [7:0] SEED     = SEED_DEF
)(
    input  logic       clk,
    input  logic       reset,
    pipe_gen_if.master bus
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int CNT_W = 4;

    state_t          r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_colcnt;
    logic [ROWS-1:0] r_next;
    logic [2:0]      r_gap_pos;
    logic            r_pipe_done;

    state_t          w_state_nxt;
    logic [CNT_W-1:0] w_colcnt_nxt;
    logic [ROWS-1:0] w_next_nxt;
    logic [2:0]      w_gap_nxt;
    logic            w_done_nxt;

    logic            w_run;
    logic            w_wrap;
    logic [7:0]      w_lfsr;
    logic [2:0]      w_pos;

    assign w_run  = bus.ongoing && !bus.gameOver;
    assign w_wrap = (r_div == DIV_W'(STEP_DIV - 1));
    assign w_pos  = gap_pos_of(w_lfsr[2:0], GAP_H);

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .i_enable (w_run),
        .o_lfsr   (w_lfsr)
    );

    // Column sequencing: columns only advance on the divider wrap, except leaving IDLE
    always_comb begin
        w_state_nxt  = r_state;
        w_colcnt_nxt = r_colcnt;
        w_next_nxt   = r_next;
        w_gap_nxt    = r_gap_pos;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt  = GAP;
                w_colcnt_nxt = '0;
                w_next_nxt   = '0;
            end
            GAP: begin
                if (w_wrap) begin
                    if (r_colcnt == CNT_W'(GAP_COLS - 1)) begin
                        w_state_nxt  = PIPE;
                        w_colcnt_nxt = '0;
                        w_gap_nxt    = w_pos;
                        w_next_nxt   = gap_mask(w_pos, GAP_H);
                    end else begin
                        w_colcnt_nxt = r_colcnt + CNT_W'(1);
                    end
                end
            end
            PIPE: begin
                if (w_wrap) begin
                    if (r_colcnt == CNT_W'(PIPE_W - 1)) begin
                        w_state_nxt  = GAP;
                        w_colcnt_nxt = '0;
                        w_next_nxt   = '0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_colcnt_nxt = r_colcnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_colcnt_nxt = '0;
                w_next_nxt   = '0;
            end
        endcase
    end

    // State register: clear while not ongoing, hold everything while gameOver
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_colcnt    <= '0;
            r_next      <= '0;
            r_gap_pos   <= '0;
            r_pipe_done <= 1'b0;
        end else if (!bus.ongoing) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_colcnt    <= '0;
            r_next      <= '0;
            r_gap_pos   <= '0;
            r_pipe_done <= 1'b0;
        end else if (bus.gameOver) begin
            r_pipe_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_colcnt    <= w_colcnt_nxt;
            r_next      <= w_next_nxt;
            r_gap_pos   <= w_gap_nxt;
            r_pipe_done <= w_done_nxt;
            r_div       <= w_wrap ? '0 : r_div + DIV_W'(1);
        end
    end

    assign bus.next      = r_next;
    assign bus.gap_pos   = r_gap_pos;
    assign bus.step      = reset && w_run && (r_div == '0);
    assign bus.pipe_done = r_pipe_done && w_run;

endmodule

// File: tb/tb_pipe_gen.sv
// tb/tb_pipe_gen.sv - self-checking bench for pipe_gen
module tb_pipe_gen;
    import pipe_pkg::*;

    localparam int         STEP_DIV = 4;
    localparam int         PIPE_W   = 2;
    localparam int         GAP_COLS = 4;
    localparam int         GAP_H    = 3;
    localparam int         PERIOD   = GAP_COLS + PIPE_W;
    localparam logic [7:0] SEED     = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_gen_if bus_if ();

    pipe_gen #(
        .STEP_DIV (STEP_DIV),
        .PIPE_W   (PIPE_W),
        .GAP_COLS (GAP_COLS),
        .GAP_H    (GAP_H),
        .SEED     (SEED)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: running flag, step divider, column index within one gap+pipe period
    bit         m_run;
    int         m_div;
    int         m_col;
    int         m_gap;
    bit         m_done;
    logic [7:0] m_lfsr;

    int c_step, c_lead, c_pipe, c_done;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] pos;
        logic [7:0] mask;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [7:0] m_mask(input int pos);
        return 8'(255 & ~(((1 << GAP_H) - 1) << pos));
    endfunction

    function automatic int m_pos(input logic [7:0] l);
        int raw;
        raw = int'(l[2:0]);
        return (raw >= ROWS - GAP_H + 1) ? raw - (ROWS - GAP_H + 1) : raw;
    endfunction

    function automatic logic [7:0] m_lfsr_next(input logic [7:0] l);
        logic fb;
        fb = l[7] ^ l[5] ^ l[4] ^ l[3];
        return {l[6:0], fb};
    endfunction

    function automatic logic [7:0] m_next();
        return (m_run && m_col >= GAP_COLS) ? m_mask(m_gap) : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for condition at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_div  = 0;
        m_col  = 0;
        m_gap  = 0;
        m_done = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic model_edge();
        bit wrap;
        if (!rst_n) begin
            model_reset();
        end else if (!bus_if.ongoing) begin
            m_run  = 1'b0;
            m_div  = 0;
            m_col  = 0;
            m_gap  = 0;
            m_done = 1'b0;
        end else if (bus_if.gameOver) begin
            m_done = 1'b0;
        end else begin
            wrap   = (m_div == STEP_DIV - 1);
            m_done = 1'b0;
            if (!m_run) begin
                m_run = 1'b1;
                m_col = 0;
            end else if (wrap) begin
                if (m_col == PERIOD - 1) m_done = 1'b1;
                m_col = (m_col + 1) % PERIOD;
                if (m_col == GAP_COLS) m_gap = m_pos(m_lfsr);
            end
            m_div  = wrap ? 0 : m_div + 1;
            m_lfsr = m_lfsr_next(m_lfsr);
        end
    endtask

    task automatic compare_all();
        logic exp_run;
        exp_run = rst_n && bus_if.ongoing && !bus_if.gameOver;
        check("next",      32'(bus_if.next),      32'(m_next()));
        check("step",      32'(bus_if.step),      32'(exp_run && m_div == 0));
        check("gap_pos",   32'(bus_if.gap_pos),   32'(m_gap));
        check("pipe_done", 32'(bus_if.pipe_done), 32'(exp_run && m_done));
        check("lfsr",      32'(dut.w_lfsr),       32'(m_lfsr));
        if (bus_if.step) begin
            c_step++;
            if (bus_if.next == 8'h00) begin
                if (c_pipe == 0) c_lead++;
            end else begin
                c_pipe++;
            end
        end
        if (bus_if.pipe_done) c_done++;
    endtask

    task automatic clear_counts();
        c_step = 0;
        c_lead = 0;
        c_pipe = 0;
        c_done = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        bit ok;

        // Gap helper table: raw LFSR bits -> opening row -> column pattern
        tbl[0] = '{raw: 3'd5, pos: 3'd5, mask: 8'b0001_1111};
        tbl[1] = '{raw: 3'd0, pos: 3'd0, mask: 8'b1111_1000};
        tbl[2] = '{raw: 3'd7, pos: 3'd1, mask: 8'b1111_0001};
        tbl[3] = '{raw: 3'd6, pos: 3'd0, mask: 8'b1111_1000};
        tbl[4] = '{raw: 3'd2, pos: 3'd2, mask: 8'b1110_0011};
        tbl[5] = '{raw: 3'd3, pos: 3'd3, mask: 8'b1100_0111};
        for (int i = 0; i < 6; i++) begin
            check("tbl_pos",  32'(gap_pos_of(tbl[i].raw, GAP_H)), 32'(tbl[i].pos));
            check("tbl_mask", 32'(gap_mask(tbl[i].pos, GAP_H)),   32'(tbl[i].mask));
        end

        // Reset, then idle with ongoing low
        bus_if.ongoing  = 1'b0;
        bus_if.gameOver = 1'b0;
        rst_n = 1'b0;
        model_reset();
        clear_counts();
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_steps", 32'(c_step), 32'd0);

        // First pipe after start: four gap steps, two pipe steps, one pipe_done
        bus_if.ongoing = 1'b1;
        clear_counts();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (c_done > 0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("first_pipe");
        check("first_lead_gaps", 32'(c_lead), 32'(GAP_COLS));
        check("first_pipe_cols", 32'(c_pipe), 32'(PIPE_W));
        check("first_done_cnt",  32'(c_done), 32'd1);

        // gameOver during the first column of the next pipe
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_run && m_col == GAP_COLS && m_div == 1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("reach_pipe_freeze");
        bus_if.gameOver = 1'b1;
        clear_counts();
        for (int i = 0; i < 20; i++) tick();
        check("freeze_steps", 32'(c_step), 32'd0);
        bus_if.gameOver = 1'b0;
        clear_counts();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (c_done > 0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("freeze_release");
        check("post_release_cols", 32'(c_pipe), 32'd1);

        // ongoing dropped mid-pipe, then restarted
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_run && m_col == GAP_COLS && m_div == 2) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("reach_pipe_drop");
        bus_if.ongoing = 1'b0;
        tick();
        check("drop_next",  32'(bus_if.next),  32'd0);
        check("drop_state", 32'(dut.r_state),  32'(IDLE));
        tick();
        bus_if.ongoing = 1'b1;
        clear_counts();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (c_pipe > 0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("restart_pipe");
        check("restart_lead_gaps", 32'(c_lead), 32'(GAP_COLS));

        // Asynchronous reset between clock edges while a pipe is on the output
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_run && m_col >= GAP_COLS) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("reach_pipe_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_next",    32'(bus_if.next),      32'd0);
        check("async_gap_pos", 32'(bus_if.gap_pos),   32'd0);
        check("async_step",    32'(bus_if.step),      32'd0);
        check("async_done",    32'(bus_if.pipe_done), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;

        // Randomized run against the reference
        for (int i = 0; i < 1500; i++) begin
            bus_if.ongoing  = ($urandom_range(0, 199) != 0);
            bus_if.gameOver = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
